// File: rtl/utpu_pkg.sv
// utpu_pkg: opcodes, controller states, ack codes and argument counts shared by the uTPU controller.
package utpu_pkg;
  typedef enum logic [7:0] {
    OP_NOP     = 8'h00,
    OP_LOAD    = 8'h01,
    OP_COMPUTE = 8'h02,
    OP_READ    = 8'h03
  } opcode_e;
  typedef enum logic [3:0] {
    IDLE, FETCH_ARG, LOAD_DATA, C_LOAD, C_RUN, C_WB, RD_ISSUE, RD_PUSH, ACK
  } ctrl_state_e;
  localparam logic [7:0] ACK_BASE = 8'hA0;
  localparam logic [7:0] ACK_ERR  = 8'hEE;
  function automatic logic [2:0] arg_count(input logic [7:0] op);
    return (op == OP_COMPUTE) ? 3'd5 : 3'd3;
  endfunction
endpackage

// File: rtl/utpu_controller_args.sv
// cmd_arg_collector: shifts in command argument bytes; the newest byte lands in the low byte.
module cmd_arg_collector (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_valid,
  input  logic [7:0]  i_data,
  input  logic [2:0]  i_need,
  output logic [39:0] o_args,
  output logic        o_done
);
  logic [39:0] r_args;
  logic [2:0]  r_cnt;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_args <= '0;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_args <= '0;
      r_cnt  <= '0;
    end else if (i_valid) begin
      r_args <= {r_args[31:0], i_data};
      r_cnt  <= r_cnt + 3'd1;
    end
  end
  assign o_args = r_args;
  assign o_done = i_valid && (r_cnt == i_need - 3'd1);
endmodule

// File: rtl/utpu_controller.sv
// utpu_controller: byte-command sequencer for the uTPU buffer, MAC array and tx FIFO.
// Define UTPU_CTRL_ACK_EN to acknowledge every command with one status byte.
module utpu_controller
  import utpu_pkg::*;
#(
  parameter int ARRAY_SIZE      = 2,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int BUFFER_SIZE     = 1024,
  parameter int ADDRESS_SIZE    = $clog2(BUFFER_SIZE)
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      rx_empty,
  output logic                                      rx_re,
  input  logic [FIFO_DATA_WIDTH-1:0]                rx_data,
  input  logic                                      tx_full,
  output logic                                      tx_we,
  output logic [FIFO_DATA_WIDTH-1:0]                tx_data,
  output logic                                      buf_we,
  output logic                                      buf_re,
  output logic                                      buf_compute_en,
  output logic                                      buf_fifo_en,
  output logic [ADDRESS_SIZE-1:0]                   buf_addr,
  output logic [FIFO_DATA_WIDTH-1:0]                buf_wdata,
  input  logic [FIFO_DATA_WIDTH-1:0]                buf_rdata,
  output logic                                      mac_load_en,
  output logic                                      mac_compute,
  output logic [$clog2(ARRAY_SIZE*ARRAY_SIZE)-1:0]  mac_out_idx,
  output logic                                      relu_en,
  output logic                                      busy,
  output logic                                      error
);
  localparam int NN = ARRAY_SIZE * ARRAY_SIZE;
  localparam int IW = $clog2(NN);
  localparam logic [15:0] K_LOAD = 16'(2 * NN);
  localparam logic [15:0] K_RUN  = 16'(3 * ARRAY_SIZE - 3);
  localparam logic [15:0] K_WB   = 16'(NN - 1);
`ifdef UTPU_CTRL_ACK_EN
  localparam ctrl_state_e DONE_ST = ACK;
`else
  localparam ctrl_state_e DONE_ST = IDLE;
`endif
  ctrl_state_e r_state, w_next;
  logic r_pend, r_bad, r_err, r_ld_we, r_held;
  logic [7:0] r_op;
  logic [15:0] r_k, w_k, w_cnt;
  logic [ADDRESS_SIZE-1:0] r_ld_addr, w_base, w_src;
  logic [FIFO_DATA_WIDTH-1:0] r_ld_data, r_hold;
  logic [39:0] w_args;
  logic w_done, w_clr, w_set_err, w_clr_err, w_unused;
  cmd_arg_collector u_args (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_clr),
    .i_valid((r_state == FETCH_ARG) && r_pend),
    .i_data (rx_data[7:0]),
    .i_need (arg_count(r_op)),
    .o_args (w_args),
    .o_done (w_done)
  );
  assign w_base   = w_args[8 +: ADDRESS_SIZE];
  assign w_src    = w_args[24 +: ADDRESS_SIZE];
  assign w_cnt    = {7'd0, w_args[7:0] == 8'd0, w_args[7:0]};
  assign busy     = r_state != IDLE;
  assign error    = r_err;
  assign w_unused = ^{w_args, r_bad, rx_data};
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_pend    <= 1'b0;
      r_op      <= '0;
      r_bad     <= 1'b0;
      r_err     <= 1'b0;
      r_k       <= '0;
      r_ld_we   <= 1'b0;
      r_ld_addr <= '0;
      r_ld_data <= '0;
      r_held    <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_state <= w_next;
      r_pend  <= rx_re;
      r_k     <= w_k;
      r_err   <= w_set_err ? 1'b1 : w_clr_err ? 1'b0 : r_err;
      if (r_state == IDLE && r_pend) begin
        r_op  <= rx_data[7:0];
        r_bad <= w_set_err;
      end
      r_ld_we <= (r_state == LOAD_DATA) && r_pend;
      if (r_state == LOAD_DATA && r_pend) begin
        r_ld_addr <= w_base + r_k[ADDRESS_SIZE-1:0];
        r_ld_data <= rx_data;
      end
      // A byte read while tx is full is parked so it survives buf_rdata changing.
      r_held <= (r_state == RD_PUSH) && tx_full;
      if (r_state == RD_PUSH && !r_held) r_hold <= buf_rdata;
    end
  end
  always_comb begin
    w_next         = r_state;
    w_k            = r_k;
    w_clr          = 1'b0;
    w_set_err      = 1'b0;
    w_clr_err      = 1'b0;
    rx_re          = 1'b0;
    tx_we          = 1'b0;
    tx_data        = '0;
    buf_we         = r_ld_we;
    buf_fifo_en    = r_ld_we;
    buf_re         = 1'b0;
    buf_compute_en = 1'b0;
    buf_addr       = r_ld_addr;
    buf_wdata      = r_ld_data;
    mac_load_en    = 1'b0;
    mac_compute    = 1'b0;
    mac_out_idx    = '0;
    relu_en        = 1'b0;
    case (r_state)
      IDLE: begin
        rx_re = !rx_empty && !r_pend;
        if (r_pend) begin
          w_clr = 1'b1;
          w_k   = '0;
          case (rx_data[7:0])
            OP_NOP: begin
              w_clr_err = 1'b1;
              w_next    = DONE_ST;
            end
            OP_LOAD, OP_COMPUTE, OP_READ: w_next = FETCH_ARG;
            default: begin
              w_set_err = 1'b1;
              w_next    = DONE_ST;
            end
          endcase
        end
      end
      FETCH_ARG: begin
        rx_re = !rx_empty && !r_pend;
        if (w_done) w_next = (r_op == OP_LOAD) ? LOAD_DATA : (r_op == OP_COMPUTE) ? C_LOAD : RD_ISSUE;
      end
      LOAD_DATA: begin
        rx_re = !rx_empty && !r_pend;
        if (r_pend) begin
          w_k = r_k + 16'd1;
          if (w_k == w_cnt) w_next = DONE_ST;
        end
      end
      C_LOAD: begin
        relu_en        = w_args[0];
        buf_re         = r_k < K_LOAD;
        buf_compute_en = buf_re;
        buf_addr       = w_src + r_k[ADDRESS_SIZE-1:0];
        mac_load_en    = r_k != 16'd0;
        w_k            = (r_k == K_LOAD) ? 16'd0 : r_k + 16'd1;
        w_next         = (r_k == K_LOAD) ? C_RUN : C_LOAD;
      end
      C_RUN: begin
        relu_en     = w_args[0];
        mac_compute = 1'b1;
        w_k         = (r_k == K_RUN) ? 16'd0 : r_k + 16'd1;
        w_next      = (r_k == K_RUN) ? C_WB : C_RUN;
      end
      C_WB: begin
        relu_en        = w_args[0];
        buf_we         = 1'b1;
        buf_compute_en = 1'b1;
        buf_addr       = w_base + r_k[ADDRESS_SIZE-1:0];
        mac_out_idx    = r_k[IW-1:0];
        w_k            = r_k + 16'd1;
        w_next         = (r_k == K_WB) ? DONE_ST : C_WB;
      end
      RD_ISSUE: begin
        if (!tx_full) begin
          buf_re   = 1'b1;
          buf_addr = w_base + r_k[ADDRESS_SIZE-1:0];
          w_next   = RD_PUSH;
        end
      end
      RD_PUSH: begin
        tx_data = r_held ? r_hold : buf_rdata;
        if (!tx_full) begin
          tx_we  = 1'b1;
          w_k    = r_k + 16'd1;
          w_next = (w_k == w_cnt) ? DONE_ST : RD_ISSUE;
        end
      end
`ifdef UTPU_CTRL_ACK_EN
      ACK: begin
        tx_data = FIFO_DATA_WIDTH'(r_bad ? ACK_ERR : (ACK_BASE | {4'h0, r_op[3:0]}));
        if (!tx_full) begin
          tx_we  = 1'b1;
          w_next = IDLE;
        end
      end
`endif
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_utpu_controller.sv
// tb_utpu_controller: directed scoreboard bench with FIFO and buffer models around utpu_controller.
module tb_utpu_controller;
  logic clk = 1'b0, rst = 1'b0;
  logic rx_empty = 1'b1, rx_re, tx_full = 1'b0, tx_we;
  logic [7:0] rx_data = '0, tx_data, buf_wdata, buf_rdata = '0;
  logic buf_we, buf_re, buf_compute_en, buf_fifo_en, mac_load_en, mac_compute, relu_en, busy, error;
  logic [9:0] buf_addr;
  logic [1:0] mac_out_idx;
  logic [7:0] rxq[$], txq[$];
  logic [7:0] mem [0:1023];
  logic s_pop = 1'b0, s_rd = 1'b0, tx_tog = 1'b0;
  logic [7:0] rd_val = '0;
  logic [3:0] tcnt = '0;
  int checks = 0, errors = 0;
  int bad_pops = 0, n_load = 0, n_comp = 0, n_crd = 0, n_wb = 0, n_busy = 0;

  always #5 clk = ~clk;

  utpu_controller dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_re(rx_re), .rx_data(rx_data),
    .tx_full(tx_full), .tx_we(tx_we), .tx_data(tx_data),
    .buf_we(buf_we), .buf_re(buf_re), .buf_compute_en(buf_compute_en), .buf_fifo_en(buf_fifo_en),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata), .buf_rdata(buf_rdata),
    .mac_load_en(mac_load_en), .mac_compute(mac_compute), .mac_out_idx(mac_out_idx),
    .relu_en(relu_en), .busy(busy), .error(error)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
  endtask

  task automatic expect_ack(input logic [7:0] b);
`ifdef UTPU_CTRL_ACK_EN
    txq.push_back(b);
`else
    b = b;
`endif
  endtask

  task automatic wait_quiet(input string tag);
    int q = 0;
    int n = 0;
    while (q < 4 && n < 3000) begin
      @(negedge clk);
      n++;
      q = (!busy && !rx_re && rxq.size() == 0 && txq.size() == 0) ? q + 1 : 0;
    end
    chk({tag, "_quiet"}, q, 4);
  endtask

  // Models sample the DUT on the falling edge and update their outputs on the rising edge.
  always @(negedge clk) begin
    s_pop  = rx_re;
    s_rd   = buf_re;
    rd_val = mem[buf_addr];
    if (rx_re && rx_empty) bad_pops++;
    if (buf_we && buf_fifo_en) mem[buf_addr] = buf_wdata;
    if (mac_load_en) n_load++;
    if (mac_compute) n_comp++;
    if (busy) n_busy++;
    if (buf_re && buf_compute_en) begin
      chk("c_rd_addr", buf_addr, 32'h010 + n_crd);
      n_crd++;
    end
    if (buf_we && buf_compute_en) begin
      chk("wb_addr", buf_addr, 32'h020 + n_wb);
      chk("wb_idx", mac_out_idx, n_wb);
      chk("wb_relu", relu_en, 1);
      n_wb++;
    end
    if (tx_we) begin
      if (tx_full) chk("tx_we_while_full", tx_full, 0);
      else if (txq.size() == 0) chk("tx_extra", txq.size(), 1);
      else chk("tx_data", tx_data, txq.pop_front());
    end
  end

  always @(posedge clk) begin
    if (s_pop && rxq.size() > 0) rx_data <= rxq.pop_front();
    rx_empty  <= rxq.size() == 0;
    buf_rdata <= s_rd ? rd_val : 8'hE7;
    tcnt      <= tcnt + 4'd1;
    tx_full   <= tx_tog && tcnt[1];
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {rx_re, tx_we, buf_we, buf_re, buf_compute_en, buf_fifo_en,
                     mac_load_en, mac_compute, relu_en, busy, error}, 0);
    chk("rst_data", {tx_data, buf_wdata, buf_addr, mac_out_idx}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    // Reset in the middle of a LOAD after two of four data bytes.
    send(8'h01); send(8'h00); send(8'h40); send(8'h04); send(8'hAA); send(8'hBB);
    repeat (25) @(negedge clk);
    chk("midload_busy", busy, 1);
    chk("midload_b0", mem[10'h040], 8'hAA);
    chk("midload_b1", mem[10'h041], 8'hBB);
    rst = 1'b0;
    @(negedge clk);
    chk("rst2_ctrl", {rx_re, tx_we, buf_we, buf_re, buf_compute_en, buf_fifo_en,
                      mac_load_en, mac_compute, relu_en, busy, error}, 0);
    chk("rst2_data", {tx_data, buf_wdata, buf_addr, mac_out_idx}, 0);
    rst = 1'b1;
    @(negedge clk);
    send(8'h00);
    expect_ack(8'hA0);
    wait_quiet("nop");
    chk("nop_err", error, 0);
    // LOAD with address wrap.
    send(8'h01); send(8'h03); send(8'hFE); send(8'h03);
    send(8'h11); send(8'h22); send(8'h33);
    expect_ack(8'hA1);
    wait_quiet("load");
    chk("load_3fe", mem[10'h3FE], 8'h11);
    chk("load_3ff", mem[10'h3FF], 8'h22);
    chk("load_000", mem[10'h000], 8'h33);
    // READ back under tx backpressure.
    txq.push_back(8'h11); txq.push_back(8'h22); txq.push_back(8'h33);
    expect_ack(8'hA3);
    tx_tog = 1'b1;
    send(8'h03); send(8'h03); send(8'hFE); send(8'h03);
    wait_quiet("read");
    tx_tog = 1'b0;
    repeat (3) @(negedge clk);
    // COMPUTE: 9-cycle load, 4 run, 4 writeback.
    n_load = 0; n_comp = 0; n_crd = 0; n_wb = 0; n_busy = 0;
    send(8'h02); send(8'h00); send(8'h10); send(8'h00); send(8'h20); send(8'h01);
    expect_ack(8'hA2);
    wait_quiet("compute");
    chk("c_load_cycles", n_load, 8);
    chk("c_rd_count", n_crd, 8);
    chk("c_run_cycles", n_comp, 4);
    chk("c_wb_count", n_wb, 4);
`ifdef UTPU_CTRL_ACK_EN
    chk("c_busy_cycles", n_busy, 28);
`else
    chk("c_busy_cycles", n_busy, 27);
`endif
    // Illegal opcode then clear.
    send(8'h7F);
    expect_ack(8'hEE);
    wait_quiet("illegal");
    chk("illegal_err", error, 1);
    send(8'h00);
    expect_ack(8'hA0);
    wait_quiet("clear");
    chk("clear_err", error, 0);
    // Starved rx FIFO: one byte every 10 cycles.
    bad_pops = 0;
    expect_ack(8'hA1);
    for (int i = 0; i < 6; i++) begin
      send(i == 0 ? 8'h01 : i == 1 ? 8'h01 : i == 2 ? 8'h00 : i == 3 ? 8'h02 : i == 4 ? 8'h5A : 8'hC3);
      repeat (10) @(negedge clk);
    end
    wait_quiet("starve");
    chk("starve_100", mem[10'h100], 8'h5A);
    chk("starve_101", mem[10'h101], 8'hC3);
    txq.push_back(8'h5A); txq.push_back(8'hC3);
    expect_ack(8'hA3);
    send(8'h03); send(8'h01); send(8'h00); send(8'h02);
    wait_quiet("starve_rd");
    chk("bad_pops", bad_pops, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
